uart_rx_fabric: RTL and testbench
=================================

UART_RX_FABRIC -- requirements
Module: uart_rx_fabric

Interface
REQ-001 The block SHALL expose parameter CLK_HZ, default 50000000, meaning the clk_clk frequency in Hz.
REQ-002 The block SHALL expose parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 The block SHALL expose parameter BIT_CLKS, default round(CLK_HZ/BAUD) (434), meaning clocks per bit, with an elaboration error if it is below 4.
REQ-004 The block SHALL have port clk_clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_reset, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have port uart_rxd, input, 1 bit, the asynchronous 8N1 serial line from the SoC uart_txd; idle is high.
REQ-007 The block SHALL have port rx_data, output, 8 bits, the received byte, valid while rx_valid=1.
REQ-008 The block SHALL have port rx_valid, output, 1 bit, indicating a byte is held.
REQ-009 The block SHALL have port rx_ready, input, 1 bit, the consumer accept signal.
REQ-010 The block SHALL have port frame_err, output, 1 bit, a one-cycle pulse on a bad stop bit.
REQ-011 The block SHALL have port overrun, output, 1 bit, a one-cycle pulse when a byte is dropped.

Function
REQ-012 uart_rxd SHALL pass through a 2-flop synchronizer (both flops reset to 1) before any use; all timing below is relative to the synchronized line rxs.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK.
REQ-014 IDLE: rxs=0 SHALL enter START and clear the bit counter (cnt) to 0.
REQ-015 START: at cnt=BIT_CLKS/2-1, rxs=0 SHALL enter DATA with cnt cleared; rxs=1 SHALL return to IDLE as a glitch, with no error pulse.
REQ-016 DATA: rxs SHALL be sampled when cnt=BIT_CLKS-1 (the bit centre), shifted in LSB first, and cnt reset; after the 8th sample the FSM SHALL enter STOP.
REQ-017 STOP: at the stop-bit centre, rxs=1 SHALL complete the byte and return to IDLE.
REQ-018 STOP: at the stop-bit centre, rxs=0 SHALL pulse frame_err for 1 cycle, discard the byte and enter BREAK.
REQ-019 BREAK SHALL remain until rxs=1, then enter IDLE; no start bit is detected while in BREAK.
REQ-020 Byte completion SHALL load rx_data and set rx_valid on the following clock (1-cycle latency from the stop-bit centre sample).
REQ-021 Handshake: a transfer occurs on a cycle with rx_valid=1 and rx_ready=1; rx_valid SHALL clear on the next clock unless a new byte completes in the same cycle, in which case the new byte is loaded and rx_valid stays 1.
REQ-022 rx_data SHALL be stable while rx_valid=1 and no transfer occurs; rx_ready while rx_valid=0 SHALL have no effect.
REQ-023 A byte that completes while rx_valid=1 and rx_ready=0 SHALL pulse overrun for 1 cycle and be dropped; the held byte is kept.
REQ-024 The receiver SHALL keep receiving regardless of rx_ready; it never back-pressures the line.
REQ-025 cnt SHALL be width clog2(BIT_CLKS) and never wrap past BIT_CLKS-1.

Reset
REQ-026 While reset_reset=1 the FSM SHALL be in IDLE, cnt=0, shift register=0, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, and synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release a low rxs SHALL be treated as a new start bit.

Structure
REQ-028 A shared package uart_pkg SHALL hold the FSM state enum and a function computing BIT_CLKS from CLK_HZ and BAUD.
REQ-029 The synchronizer SHALL be a separate sub-module, sync2, with a reset value parameter; everything else is in one module.

Verification (CLK_HZ=1000000, BAUD=100000, BIT_CLKS=10)
REQ-030 A frame of 0xA5 with valid stop and rx_ready=1 -> rx_data=0xA5 and rx_valid=1 for exactly 1 cycle, 1 clock after the stop-bit centre.
REQ-031 Frames 0x3C then 0x7E back-to-back, with rx_ready=0 until both complete -> rx_data=0x3C held, overrun pulses once, and 0x3C is delivered when rx_ready rises.
REQ-032 A 3-clock low glitch on uart_rxd -> no rx_valid and no frame_err; a following 0x55 frame is received correctly.
REQ-033 Frame 0xFF with stop bit 0 and the line held low 30 clocks -> frame_err pulse 1 cycle, no rx_valid, and a later 0x01 frame is received correctly.
REQ-034 reset_reset pulsed during data bit 4 of a frame -> all outputs are at reset values and no byte is delivered from the aborted frame; the next 0x81 frame is received correctly.
REQ-035 rx_ready asserted in the same cycle a new byte completes while 0x11 is held -> 0x11 transfers, the new byte 0x22 loads, rx_valid stays 1, and no overrun pulse occurs.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and bit-period helper.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int bit_clks(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer with a parameterised reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_fabric.sv
// uart_rx_fabric: 8N1 UART receiver with a one-byte valid/ready holding register.
module uart_rx_fabric
    import uart_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int BAUD     = 115200,
    parameter int BIT_CLKS = bit_clks(CLK_HZ, BAUD)
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BIT_CLKS - 1);

    generate
        if (BIT_CLKS < 4) begin : g_bit_clks_check
            $error("uart_rx_fabric: BIT_CLKS must be at least 4");
        end
    endgenerate

    logic          rxs;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          done, bad_stop;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk(clk_clk),
        .rst(reset_reset),
        .d  (uart_rxd),
        .q  (rxs)
    );

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        done        = 1'b0;
        bad_stop    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    state_nxt = S_START;
                    cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    // A start bit that is high again at its centre was a glitch.
                    state_nxt   = rxs ? S_IDLE : S_DATA;
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == FULL_LAST) begin
                    shreg_nxt   = {rxs, shreg[7:1]};
                    cnt_nxt     = '0;
                    bit_idx_nxt = bit_idx + 3'd1;
                    state_nxt   = (bit_idx == 3'd7) ? S_STOP : S_DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt == FULL_LAST) begin
                    done      = rxs;
                    bad_stop  = !rxs;
                    state_nxt = rxs ? S_IDLE : S_BREAK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_BREAK: begin
                state_nxt = rxs ? S_IDLE : S_BREAK;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            frame_err <= bad_stop;
            overrun   <= done && rx_valid && !rx_ready;
            // A completing byte may replace the held one only when it is being taken.
            if (done && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fabric.sv
// tb_uart_rx_fabric: scenario tasks driving 8N1 frames, checked against frame-level expectations.
module tb_uart_rx_fabric;

    localparam int B   = 10;
    // sync (2) + start detect (1) + half bit + 8 data bits + stop bit, then 1 clock to load
    localparam int LAT = 3 + B / 2 + 9 * B;

    logic       clk_clk     = 1'b0;
    logic       reset_reset = 1'b1;
    logic       uart_rxd    = 1'b1;
    logic       rx_ready    = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         vcyc   = 0;
    int         rise_cyc = -1;
    logic       prev_v = 1'b0;
    logic [7:0] got[$];

    uart_rx_fabric #(.CLK_HZ(1000000), .BAUD(100000)) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .uart_rxd   (uart_rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) cyc <= cyc + 1;

    // Records transfers and pulse widths, sampled mid-cycle.
    always @(negedge clk_clk) begin
        if (reset_reset) begin
            prev_v <= 1'b0;
        end else begin
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (frame_err) fe_cnt <= fe_cnt + 1;
            if (overrun) ov_cnt <= ov_cnt + 1;
            if (rx_valid) vcyc <= vcyc + 1;
            if (rx_valid && !prev_v) rise_cyc <= cyc;
            prev_v <= rx_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic hold(input logic v, input int n);
        uart_rxd = v;
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        hold(1'b0, B);
        for (int i = 0; i < 8; i++) hold(b[i], B);
        hold(stop, B);
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) @(posedge clk_clk);
        #1;
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b want 0", overrun); end
        reset_reset = 1'b0;
        hold(1'b1, 3);
    endtask

    task automatic test_single();
        int c0, f0, o0, v0;
        rx_ready = 1'b1;
        got.delete();
        f0 = fe_cnt; o0 = ov_cnt; v0 = vcyc; c0 = cyc;
        send(8'hA5, 1'b1);
        hold(1'b1, 5);
        total++; if (rise_cyc - c0 !== LAT) begin bad++; $display("FAIL single_latency: got %0d want %0d", rise_cyc - c0, LAT); end
        total++; if (vcyc - v0 !== 1) begin bad++; $display("FAIL single_valid_width: got %0d want 1", vcyc - v0); end
        total++; if (got.size() !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", got.size()); end
        else begin
            total++; if (got[0] !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", got[0]); end
        end
        total++; if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin bad++; $display("FAIL single_pulses: got ferr %0d ovr %0d want 0 0", fe_cnt - f0, ov_cnt - o0); end
    endtask

    task automatic test_overrun();
        int o0;
        rx_ready = 1'b0;
        got.delete();
        o0 = ov_cnt;
        send(8'h3C, 1'b1);
        send(8'h7E, 1'b1);
        hold(1'b1, 5);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
        total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL ovr_held: got %h want 3c", rx_data); end
        total++; if (ov_cnt - o0 !== 1) begin bad++; $display("FAIL ovr_pulse: got %0d want 1", ov_cnt - o0); end
        total++; if (got.size() !== 0) begin bad++; $display("FAIL ovr_early: got %0d transfers want 0", got.size()); end
        rx_ready = 1'b1;
        @(posedge clk_clk);
        #1;
        rx_ready = 1'b0;
        total++; if (got.size() !== 1) begin bad++; $display("FAIL ovr_deliver_count: got %0d want 1", got.size()); end
        else begin
            total++; if (got[0] !== 8'h3C) begin bad++; $display("FAIL ovr_deliver: got %h want 3c", got[0]); end
        end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b want 0", rx_valid); end
    endtask

    task automatic test_glitch();
        int f0, v0;
        rx_ready = 1'b1;
        got.delete();
        f0 = fe_cnt; v0 = vcyc;
        hold(1'b0, 3);
        hold(1'b1, 2 * B);
        total++; if (vcyc - v0 !== 0) begin bad++; $display("FAIL glitch_valid: got %0d valid cycles want 0", vcyc - v0); end
        send(8'h55, 1'b1);
        hold(1'b1, 5);
        total++; if (fe_cnt - f0 !== 0) begin bad++; $display("FAIL glitch_ferr: got %0d want 0", fe_cnt - f0); end
        total++; if (got.size() !== 1) begin bad++; $display("FAIL glitch_count: got %0d want 1", got.size()); end
        else begin
            total++; if (got[0] !== 8'h55) begin bad++; $display("FAIL glitch_data: got %h want 55", got[0]); end
        end
    endtask

    task automatic test_break();
        int f0, v0;
        rx_ready = 1'b1;
        got.delete();
        f0 = fe_cnt; v0 = vcyc;
        send(8'hFF, 1'b0);
        hold(1'b0, 30);
        total++; if (fe_cnt - f0 !== 1) begin bad++; $display("FAIL break_ferr: got %0d cycles want 1", fe_cnt - f0); end
        total++; if (vcyc - v0 !== 0) begin bad++; $display("FAIL break_valid: got %0d valid cycles want 0", vcyc - v0); end
        hold(1'b1, 2 * B);
        send(8'h01, 1'b1);
        hold(1'b1, 5);
        total++; if (got.size() !== 1) begin bad++; $display("FAIL break_count: got %0d want 1", got.size()); end
        else begin
            total++; if (got[0] !== 8'h01) begin bad++; $display("FAIL break_data: got %h want 01", got[0]); end
        end
        total++; if (fe_cnt - f0 !== 1) begin bad++; $display("FAIL break_ferr_after: got %0d want 1", fe_cnt - f0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int f0;
        rx_ready = 1'b0;
        send(8'h5A, 1'b1);
        hold(1'b1, 5);
        got.delete();
        f0 = fe_cnt;
        b = 8'hC3;
        hold(1'b0, B);
        for (int i = 0; i < 4; i++) hold(b[i], B);
        hold(b[4], 5);
        reset_reset = 1'b1;
        uart_rxd = 1'b1;
        repeat (2) @(posedge clk_clk);
        #1;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
        total++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL rstmid_pulses: got %b%b want 00", frame_err, overrun); end
        reset_reset = 1'b0;
        rx_ready = 1'b1;
        hold(1'b1, 3 * B);
        total++; if (got.size() !== 0) begin bad++; $display("FAIL rstmid_nodeliver: got %0d want 0", got.size()); end
        send(8'h81, 1'b1);
        hold(1'b1, 5);
        total++; if (got.size() !== 1) begin bad++; $display("FAIL rstmid_count: got %0d want 1", got.size()); end
        else begin
            total++; if (got[0] !== 8'h81) begin bad++; $display("FAIL rstmid_data_after: got %h want 81", got[0]); end
        end
        total++; if (fe_cnt - f0 !== 0) begin bad++; $display("FAIL rstmid_ferr: got %0d want 0", fe_cnt - f0); end
    endtask

    task automatic test_same_cycle();
        int c0, o0;
        rx_ready = 1'b0;
        send(8'h11, 1'b1);
        hold(1'b1, 5);
        got.delete();
        o0 = ov_cnt;
        c0 = cyc;
        fork
            send(8'h22, 1'b1);
            begin
                wait (cyc == c0 + LAT - 1);
                #1;
                rx_ready = 1'b1;
                wait (cyc == c0 + LAT);
                #1;
                rx_ready = 1'b0;
                total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL same_valid: got %b want 1", rx_valid); end
                total++; if (rx_data !== 8'h22) begin bad++; $display("FAIL same_data: got %h want 22", rx_data); end
                total++; if (got.size() !== 1) begin bad++; $display("FAIL same_xfer_count: got %0d want 1", got.size()); end
                else begin
                    total++; if (got[0] !== 8'h11) begin bad++; $display("FAIL same_xfer: got %h want 11", got[0]); end
                end
            end
        join
        hold(1'b1, 5);
        total++; if (ov_cnt - o0 !== 0) begin bad++; $display("FAIL same_ovr: got %0d want 0", ov_cnt - o0); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL same_still_held: got %b want 1", rx_valid); end
        rx_ready = 1'b1;
        @(posedge clk_clk);
        #1;
        total++; if (got.size() !== 2) begin bad++; $display("FAIL same_drain_count: got %0d want 2", got.size()); end
        else begin
            total++; if (got[1] !== 8'h22) begin bad++; $display("FAIL same_drain: got %h want 22", got[1]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int f0, o0;
        rx_ready = 1'b1;
        got.delete();
        f0 = fe_cnt; o0 = ov_cnt;
        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send(b, 1'b1);
            hold(1'b1, $urandom_range(0, 15));
        end
        hold(1'b1, 5);
        total++; if (got.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", got.size(), exp_q.size()); end
        else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                total++; if (got[k] !== exp_q[k]) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", k, got[k], exp_q[k]); end
            end
        end
        total++; if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin bad++; $display("FAIL rand_pulses: got ferr %0d ovr %0d want 0 0", fe_cnt - f0, ov_cnt - o0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_glitch();
        test_break();
        test_reset_mid();
        test_same_cycle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
